key_schedule_ctrl: RTL and testbench

Sequential AES-128 key-schedule controller. It generates the 11 round keys one round per clock from a latched 128-bit cipher key, sharing a single 4-lane S-box bank (4 × `sbox`, `endereco`/`dado` ports) across all 10 expansion rounds. It stores the result in an internal round-key register file and serves it through a flat output and an indexed read port. It sits between the I2C key-load path and the AES round datapath, replacing the fully unrolled combinational expansion with a 10-cycle iterative one.

---
 rtl/key_schedule_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_key_schedule_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/key_schedule_ctrl.sv
// key_schedule_ctrl: iterative AES-128 key expansion, one round key per clock.
// A single 4-lane S-box bank is shared across all 10 expansion rounds.
// Ports:
//   clk, rst       - system clock, synchronous active-high reset
//   start, key     - expansion request and 128-bit cipher key (sampled on accept)
//   busy, done     - registered status (expansion running / all keys valid)
//   round_key_flat - all 11 round keys, key r at [r*128 +: 128]
//   rk_idx         - read index 0..10
//   rk_data        - round key rk_idx (combinational), 0 for idx > 10
//   rk_valid       - done and rk_idx <= 10

// sbox: AES forward substitution for one byte lane.
module sbox (
  input  logic [7:0] endereco,
  output logic [7:0] dado
);

  localparam logic [0:255][7:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign dado = SBOX_TABLE[endereco];

endmodule

module key_schedule_ctrl (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [127:0]  key,
  output logic          busy,
  output logic          done,
  output logic [1407:0] round_key_flat,
  input  logic [3:0]    rk_idx,
  output logic [127:0]  rk_data,
  output logic          rk_valid
);

  localparam int unsigned KEY_W  = 128;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned NUM_RK = 11;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(NUM_RK - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         rcon_q, rcon_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               rk_we;
  logic [CNT_W-1:0]   rk_wsel;
  logic [KEY_W-1:0]   rk_wdata;
  logic [KEY_W-1:0]   rk [0:NUM_RK-1];

  logic [KEY_W-1:0]   prev;
  logic [WORD_W-1:0]  w0, w1, w2, w3;
  logic [WORD_W-1:0]  rot_w3;
  logic [WORD_W-1:0]  sbox_in, sbox_out;
  logic [WORD_W-1:0]  t_word;
  logic [WORD_W-1:0]  n0, n1, n2, n3;
  logic [7:0]         rcon_next;

  // Previous round key rk[cnt-1]
  always_comb begin
    prev = '0;
    for (int i = 0; i < int'(NUM_RK); i++) begin
      if (CNT_W'(i) == cnt_q - CNT_W'(1)) prev = rk[i];
    end
  end

  assign w0     = prev[127:96];
  assign w1     = prev[95:64];
  assign w2     = prev[63:32];
  assign w3     = prev[31:0];
  assign rot_w3 = {w3[23:0], w3[31:24]};

  // S-box inputs are parked at zero outside EXPAND to avoid needless toggling
  assign sbox_in = (state_q == EXPAND) ? rot_w3 : '0;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    sbox u_sbox (
      .endereco (sbox_in[g*8 +: 8]),
      .dado     (sbox_out[g*8 +: 8])
    );
  end

  assign t_word = sbox_out ^ {rcon_q, 24'h0};
  assign n0     = w0 ^ t_word;
  assign n1     = w1 ^ n0;
  assign n2     = w2 ^ n1;
  assign n3     = w3 ^ n2;

  // xtime in GF(2^8)
  assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rcon_d   = rcon_q;
    busy_d   = busy_q;
    done_d   = done_q;
    rk_we    = 1'b0;
    rk_wsel  = '0;
    rk_wdata = '0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          rk_we    = 1'b1;
          rk_wsel  = '0;
          rk_wdata = key;
          rcon_d   = 8'h01;
          cnt_d    = CNT_W'(1);
          busy_d   = 1'b1;
          done_d   = 1'b0;
          state_d  = EXPAND;
        end
      end
      EXPAND: begin
        rk_we    = 1'b1;
        rk_wsel  = cnt_q;
        rk_wdata = {n0, n1, n2, n3};
        cnt_d    = cnt_q + CNT_W'(1);
        rcon_d   = rcon_next;
        if (cnt_q == LAST_RND) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State, control and round-key storage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rcon_q  <= 8'h01;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < int'(NUM_RK); i++) rk[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcon_q  <= rcon_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (rk_we) begin
        for (int i = 0; i < int'(NUM_RK); i++) begin
          if (rk_wsel == CNT_W'(i)) rk[i] <= rk_wdata;
        end
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_RK); g++) begin : g_flat
    assign round_key_flat[g*KEY_W +: KEY_W] = rk[g];
  end

  // Indexed read port; indices past the last round key read as zero
  always_comb begin
    rk_data = '0;
    for (int i = 0; i < int'(NUM_RK); i++) begin
      if (rk_idx == CNT_W'(i)) rk_data = rk[i];
    end
  end

  assign rk_valid = done_q && (rk_idx <= LAST_RND);
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// tb_key_schedule_ctrl: directed self-checking bench for key_schedule_ctrl
// using the FIPS-197 and all-zero key expansions.
module tb_key_schedule_ctrl;

  logic          clk;
  logic          rst;
  logic          start;
  logic [127:0]  key;
  logic          busy;
  logic          done;
  logic [1407:0] round_key_flat;
  logic [3:0]    rk_idx;
  logic [127:0]  rk_data;
  logic          rk_valid;

  int checks   = 0;
  int failures = 0;

  logic [127:0] fips_rk [0:10];
  logic [127:0] zero_rk [0:10];

  key_schedule_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .key            (key),
    .busy           (busy),
    .done           (done),
    .round_key_flat (round_key_flat),
    .rk_idx         (rk_idx),
    .rk_data        (rk_data),
    .rk_valid       (rk_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Accept a key, then follow the expansion edge by edge until done (bounded).
  // With disturb set, start is re-asserted and key scrambled during EXPAND.
  task automatic run(input string name, input logic [127:0] k, input bit disturb,
                     input logic [127:0] want [0:10]);
    int n;
    int busy_n;
    @(negedge clk);
    start = 1'b1;
    key   = k;
    @(negedge clk);
    start = 1'b0;
    check({name, "_acc_busy"}, 128'(busy), 128'(1));
    check({name, "_acc_done"}, 128'(done), 128'(0));
    check({name, "_rk0"}, round_key_flat[127:0], want[0]);
    n      = 0;
    busy_n = busy ? 1 : 0;
    while (!done && n < 30) begin
      if (disturb && n < 5) begin
        start = 1'b1;
        key   = key ^ 128'h0123456789abcdeffedcba9876543210;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
      if (busy) busy_n++;
      if (n <= 10) check($sformatf("%s_rk%0d", name, n), round_key_flat[n*128 +: 128], want[n]);
    end
    start = 1'b0;
    check({name, "_latency"}, 128'(n), 128'(10));
    check({name, "_busy_cycles"}, 128'(busy_n), 128'(10));
    check({name, "_end_busy"}, 128'(busy), 128'(0));
    check({name, "_end_done"}, 128'(done), 128'(1));
  endtask

  initial begin
    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    zero_rk[0]  = 128'h00000000000000000000000000000000;
    zero_rk[1]  = 128'h62636363626363636263636362636363;
    zero_rk[2]  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
    zero_rk[3]  = 128'h90973450696ccffaf2f457330b0fac99;
    zero_rk[4]  = 128'hee06da7b876a1581759e42b27e91ee2b;
    zero_rk[5]  = 128'h7f2e2b88f8443e098dda7cbbf34b9290;
    zero_rk[6]  = 128'hec614b851425758c99ff09376ab49ba7;
    zero_rk[7]  = 128'h217517873550620bacaf6b3cc61bf09b;
    zero_rk[8]  = 128'h0ef903333ba9613897060a04511dfa9f;
    zero_rk[9]  = 128'hb1d4d8e28a7db9da1d7bb3de4c664941;
    zero_rk[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    rst    = 1'b1;
    start  = 1'b0;
    key    = '0;
    rk_idx = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_flat_nonzero", 128'(|round_key_flat), 128'(0));
    check("rst_rk_data", rk_data, 128'(0));
    check("rst_rk_valid", 128'(rk_valid), 128'(0));

    // FIPS-197 key, plain pulse
    run("fips", fips_rk[0], 1'b0, fips_rk);

    // Index sweep after done
    for (int i = 0; i < 16; i++) begin
      rk_idx = 4'(i);
      #1;
      check($sformatf("sweep_data%0d", i), rk_data, (i <= 10) ? fips_rk[i] : 128'(0));
      check($sformatf("sweep_valid%0d", i), 128'(rk_valid), (i <= 10) ? 128'(1) : 128'(0));
    end
    rk_idx = 4'd0;

    // Back-to-back restart from DONE with the zero key
    run("zero", zero_rk[0], 1'b0, zero_rk);

    // start and key disturbed during EXPAND must not alter the result
    run("disturb", fips_rk[0], 1'b1, fips_rk);

    // Reset in the middle of EXPAND
    @(negedge clk);
    start = 1'b1;
    key   = fips_rk[0];
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy_before_rst", 128'(busy), 128'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_done", 128'(done), 128'(0));
    check("abort_flat_nonzero", 128'(|round_key_flat), 128'(0));
    check("abort_rk_valid", 128'(rk_valid), 128'(0));

    // Fresh run after abort
    run("fips2", fips_rk[0], 1'b0, fips_rk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
